// File: rtl/snake_food_if.sv
// snake_food_if: bus between the snake core and the food controller.
//   tick              game tick pulse from the core
//   head_x/head_y     snake head position, pixels
//   body1_x/body1_y   first body segment position, pixels
//   food_x/food_y     food position, pixels (cell * CELL)
//   food_valid        food placed and drawable
//   eat_evt           level to the core, high from detection through next tick
//   score             foods eaten, saturating
// Modports: master = core side, slave = food controller side.
interface snake_food_if #(
  parameter int unsigned SCORE_W = 8
) ();
  logic               tick;
  logic [9:0]         head_x;
  logic [8:0]         head_y;
  logic [9:0]         body1_x;
  logic [8:0]         body1_y;
  logic [9:0]         food_x;
  logic [8:0]         food_y;
  logic               food_valid;
  logic               eat_evt;
  logic [SCORE_W-1:0] score;

  modport master (
    output tick, head_x, head_y, body1_x, body1_y,
    input  food_x, food_y, food_valid, eat_evt, score
  );

  modport slave (
    input  tick, head_x, head_y, body1_x, body1_y,
    output food_x, food_y, food_valid, eat_evt, score
  );
endinterface

// File: rtl/snake_food.sv
// snake_food: places food on the playfield from a free-running LFSR, watches
// the snake head for a hit, raises eat_evt to the core and keeps a score.
// Ports:
//   clk_pix   single clock
//   reset     synchronous, active-high reset
//   sf        snake_food_if.slave (tick/head/body in, food/eat/score out)
// Optional feature: define SNAKE_FOOD_AVOID_EN to reject candidate cells that
// sit under the snake head or first body segment (the fallback cell is exempt).
module snake_food #(
  parameter int unsigned CELL      = 10,
  parameter int unsigned GRID_W    = 64,
  parameter int unsigned GRID_H    = 48,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned SCORE_W   = 8,
  parameter int unsigned MAX_TRIES = 64
) (
  input logic         clk_pix,
  input logic         reset,
  snake_food_if.slave sf
);

  // A zero seed would lock the LFSR, so it is replaced.
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam int unsigned TRY_W     = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [9:0]  FB_X      = 10'((GRID_W - 2) * CELL);
  localparam logic [8:0]  FB_Y      = 9'((GRID_H - 2) * CELL);

  typedef enum logic [1:0] {
    ST_PLACE = 2'd0,
    ST_ARMED = 2'd1,
    ST_EATEN = 2'd2
  } state_e;

  state_e             state_q;
  logic [15:0]        lfsr_q;
  logic [TRY_W-1:0]   try_q;
  logic [9:0]         food_x_q;
  logic [8:0]         food_y_q;
  logic               food_valid_q;
  logic               eat_evt_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;

  logic               lfsr_fb;
  logic [5:0]         cand_gx;
  logic [5:0]         cand_gy;
  logic [9:0]         cand_x;
  logic [8:0]         cand_y;
  logic               border_ok;
  logic               cand_legal;
  logic               head_match;

  // Fibonacci feedback, taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Candidate cell and its pixel position (truncated to the bus widths).
  assign cand_gx = lfsr_q[5:0];
  assign cand_gy = lfsr_q[11:6];
  assign cand_x  = 10'(32'(cand_gx) * CELL);
  assign cand_y  = 9'(32'(cand_gy) * CELL);

  // Keep food one cell inside the border on every side.
  assign border_ok = (cand_gx != 6'd0) && (32'(cand_gx) <= (GRID_W - 32'd2)) &&
                     (cand_gy != 6'd0) && (32'(cand_gy) <= (GRID_H - 32'd2));

`ifdef SNAKE_FOOD_AVOID_EN
  assign cand_legal = border_ok &&
                      !((cand_x == sf.head_x)  && (cand_y == sf.head_y)) &&
                      !((cand_x == sf.body1_x) && (cand_y == sf.body1_y));
`else
  logic unused_body;
  assign unused_body = ^{sf.body1_x, sf.body1_y};
  assign cand_legal  = border_ok;
`endif

  assign head_match = (sf.head_x == food_x_q) && (sf.head_y == food_y_q);

  // Score saturates at all-ones instead of wrapping.
  assign score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

  // Placement / armed / eaten sequencing; LFSR free-runs in every state.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q      <= ST_PLACE;
      lfsr_q       <= SEED;
      try_q        <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      eat_evt_q    <= 1'b0;
      score_q      <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      case (state_q)
        ST_PLACE: begin
          if (try_q == TRY_LIMIT) begin
            // Out of attempts: take the fallback cell without any check.
            food_x_q     <= FB_X;
            food_y_q     <= FB_Y;
            food_valid_q <= 1'b1;
            state_q      <= ST_ARMED;
          end else if (cand_legal) begin
            food_x_q     <= cand_x;
            food_y_q     <= cand_y;
            food_valid_q <= 1'b1;
            state_q      <= ST_ARMED;
          end else begin
            try_q <= try_q + TRY_W'(1);
          end
        end
        ST_ARMED: begin
          // tick is ignored here, so a tick coinciding with the hit is not the consuming one.
          if (head_match) begin
            eat_evt_q <= 1'b1;
            state_q   <= ST_EATEN;
          end
        end
        ST_EATEN: begin
          if (sf.tick) begin
            eat_evt_q    <= 1'b0;
            food_valid_q <= 1'b0;
            score_q      <= score_d;
            try_q        <= '0;
            state_q      <= ST_PLACE;
          end
        end
        default: begin
          state_q <= ST_PLACE;
        end
      endcase
    end
  end

  assign sf.food_x     = food_x_q;
  assign sf.food_y     = food_y_q;
  assign sf.food_valid = food_valid_q;
  assign sf.eat_evt    = eat_evt_q;
  assign sf.score      = score_q;

endmodule
